// File: rtl/tank_controller.sv
// Tank controller: player tank motion with bound clamping, plus a
// single-bullet launcher that sequences IDLE -> FLIGHT -> COOLDOWN.
// Every output is a register; all motion advances only on frame_tick.
module tank_controller #(
  parameter int START_X         = 64,
  parameter int START_Y         = 416,
  parameter int TANK_SPEED      = 1,
  parameter int BULLET_SPEED    = 4,
  parameter int COOLDOWN_FRAMES = 8,
  parameter int PARK            = 1000
) (
  input  logic       vga_clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic [3:0] dir_req,
  input  logic       fire_btn,
  input  logic       bullet_hit,
  input  logic       tank_hit,
  output logic [9:0] tankx,
  output logic [9:0] tanky,
  output logic [3:0] TankDir,
  output logic       show_tank,
  output logic [9:0] bullet_x,
  output logic [9:0] bullet_y,
  output logic [3:0] bullet_dir,
  output logic       bullet_active
);

  localparam logic [10:0] TSPD   = 11'(TANK_SPEED);
  localparam logic [10:0] BSPD   = 11'(BULLET_SPEED);
  localparam logic [10:0] TX_MAX = 11'd608;
  localparam logic [10:0] TY_MAX = 11'd448;
  localparam logic [10:0] BX_MAX = 11'd632;
  localparam logic [10:0] BY_MAX = 11'd472;
  localparam logic [9:0]  PARK_V = 10'(PARK);
  localparam int          CW     = $clog2(COOLDOWN_FRAMES + 2);
  localparam logic [CW-1:0] CD_LOAD = CW'(COOLDOWN_FRAMES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FLIGHT,
    S_COOL
  } bstate_t;

  // Decrement that saturates at zero; the compare precedes the subtract so
  // the unsigned result can never wrap.
  function automatic logic [9:0] sat_dec(input logic [9:0] v, input logic [10:0] d);
    logic [10:0] w;
    w = {1'b0, v};
    if (w >= d) return 10'(w - d);
    else        return 10'd0;
  endfunction

  // Increment that saturates at the given upper bound.
  function automatic logic [9:0] sat_inc(input logic [9:0] v, input logic [10:0] d,
                                         input logic [10:0] max);
    logic [11:0] s;
    s = {2'b00, v} + {1'b0, d};
    if (s > {1'b0, max}) return 10'(max);
    else                 return 10'(s);
  endfunction

  // Up beats Down beats Left beats Right when several buttons are held.
  function automatic logic [3:0] pick_dir(input logic [3:0] r);
    if (r[0])      return 4'b0001;
    else if (r[1]) return 4'b0010;
    else if (r[2]) return 4'b0100;
    else           return 4'b1000;
  endfunction

  logic          alive;
  logic [3:0]    mv_dir;
  logic          fire_prev;
  logic          fire_edge;
  bstate_t       state, state_n;
  logic [CW-1:0] cd_cnt, cd_n;
  logic [9:0]    bx_n, by_n;
  logic [3:0]    bdir_n;
  logic          bact_n;
  logic          spawn_ok;
  logic [9:0]    spawn_x, spawn_y;
  logic          step_ok;
  logic [9:0]    step_x, step_y;

  // A hit in this very cycle already disables the tank's controls.
  assign alive     = show_tank & ~tank_hit;
  assign mv_dir    = pick_dir(dir_req);
  assign fire_edge = fire_btn & ~fire_prev;

  // Tank position, facing, liveness and the fire-button history register.
  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      tankx     <= 10'(START_X);
      tanky     <= 10'(START_Y);
      TankDir   <= 4'b0001;
      show_tank <= 1'b1;
      fire_prev <= 1'b1;
    end else begin
      fire_prev <= fire_btn;
      if (tank_hit) show_tank <= 1'b0;
      if (frame_tick && alive && (dir_req != 4'b0000)) begin
        TankDir <= mv_dir;
        case (mv_dir)
          4'b0001: tanky <= sat_dec(tanky, TSPD);
          4'b0010: tanky <= sat_inc(tanky, TSPD, TY_MAX);
          4'b0100: tankx <= sat_dec(tankx, TSPD);
          default: tankx <= sat_inc(tankx, TSPD, TX_MAX);
        endcase
      end
    end
  end

  // Launch point just ahead of the tank's barrel, from the registered
  // (pre-move) tank position, and whether it still lies on the field.
  always_comb begin
    spawn_ok = 1'b0;
    spawn_x  = tankx;
    spawn_y  = tanky;
    case (TankDir)
      4'b0001: begin
        spawn_ok = ({1'b0, tanky} >= 11'd8) && ({1'b0, tankx} + 11'd12 <= BX_MAX);
        spawn_x  = 10'({1'b0, tankx} + 11'd12);
        spawn_y  = 10'({1'b0, tanky} - 11'd8);
      end
      4'b0010: begin
        spawn_ok = ({1'b0, tanky} + 11'd32 <= BY_MAX) && ({1'b0, tankx} + 11'd12 <= BX_MAX);
        spawn_x  = 10'({1'b0, tankx} + 11'd12);
        spawn_y  = 10'({1'b0, tanky} + 11'd32);
      end
      4'b0100: begin
        spawn_ok = ({1'b0, tankx} >= 11'd8) && ({1'b0, tanky} + 11'd12 <= BY_MAX);
        spawn_x  = 10'({1'b0, tankx} - 11'd8);
        spawn_y  = 10'({1'b0, tanky} + 11'd12);
      end
      4'b1000: begin
        spawn_ok = ({1'b0, tankx} + 11'd32 <= BX_MAX) && ({1'b0, tanky} + 11'd12 <= BY_MAX);
        spawn_x  = 10'({1'b0, tankx} + 11'd32);
        spawn_y  = 10'({1'b0, tanky} + 11'd12);
      end
      default: spawn_ok = 1'b0;
    endcase
  end

  // Next bullet position one frame ahead, flagged if it would leave the field.
  always_comb begin
    step_ok = 1'b0;
    step_x  = bullet_x;
    step_y  = bullet_y;
    case (bullet_dir)
      4'b0001: begin
        step_ok = ({1'b0, bullet_y} >= BSPD);
        step_y  = 10'({1'b0, bullet_y} - BSPD);
      end
      4'b0010: begin
        step_ok = ({1'b0, bullet_y} + BSPD <= BY_MAX);
        step_y  = 10'({1'b0, bullet_y} + BSPD);
      end
      4'b0100: begin
        step_ok = ({1'b0, bullet_x} >= BSPD);
        step_x  = 10'({1'b0, bullet_x} - BSPD);
      end
      4'b1000: begin
        step_ok = ({1'b0, bullet_x} + BSPD <= BX_MAX);
        step_x  = 10'({1'b0, bullet_x} + BSPD);
      end
      default: step_ok = 1'b0;
    endcase
  end

  // Bullet FSM next-state and next-output logic; a hit outranks a frame move.
  always_comb begin
    logic go_cool;
    go_cool = 1'b0;
    state_n = state;
    cd_n    = cd_cnt;
    bx_n    = bullet_x;
    by_n    = bullet_y;
    bdir_n  = bullet_dir;
    bact_n  = bullet_active;
    case (state)
      S_IDLE: begin
        if (fire_edge && alive && spawn_ok) begin
          state_n = S_FLIGHT;
          bx_n    = spawn_x;
          by_n    = spawn_y;
          bdir_n  = TankDir;
          bact_n  = 1'b1;
        end
      end
      S_FLIGHT: begin
        if (bullet_hit) begin
          go_cool = 1'b1;
        end else if (frame_tick) begin
          if (step_ok) begin
            bx_n = step_x;
            by_n = step_y;
          end else begin
            go_cool = 1'b1;
          end
        end
      end
      S_COOL: begin
        if (frame_tick) begin
          if (cd_cnt <= CW'(1)) begin
            state_n = S_IDLE;
            cd_n    = '0;
          end else begin
            cd_n = cd_cnt - CW'(1);
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
    if (go_cool) begin
      state_n = S_COOL;
      bact_n  = 1'b0;
      bx_n    = PARK_V;
      by_n    = PARK_V;
      cd_n    = CD_LOAD;
    end
  end

  // Bullet FSM state and registered bullet outputs.
  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      state         <= S_IDLE;
      cd_cnt        <= '0;
      bullet_x      <= PARK_V;
      bullet_y      <= PARK_V;
      bullet_dir    <= 4'b0001;
      bullet_active <= 1'b0;
    end else begin
      state         <= state_n;
      cd_cnt        <= cd_n;
      bullet_x      <= bx_n;
      bullet_y      <= by_n;
      bullet_dir    <= bdir_n;
      bullet_active <= bact_n;
    end
  end

endmodule

// File: doc/tank_controller.md
TANK_CONTROLLER -- requirements
Module: tank_controller

Interface
REQ-001 Parameters (name, default, meaning): START_X 64 (reset tank x); START_Y 416 (reset tank y); TANK_SPEED 1 (px per frame); BULLET_SPEED 4 (px per frame); COOLDOWN_FRAMES 8 (frames between shots); PARK 1000 (off-screen bullet coordinate).
REQ-002 vga_clk  in  1  sole clock; all state changes on rising edge.
REQ-003 Reset  in  1  synchronous, active-high reset.
REQ-004 frame_tick  in  1  one-cycle pulse per video frame; all motion happens only on it.
REQ-005 dir_req  in  4  held movement request, one-hot: bit0 Up, bit1 Down, bit2 Left, bit3 Right.
REQ-006 fire_btn  in  1  level fire button.
REQ-007 bullet_hit  in  1  bullet collided (external collision logic); terminates flight.
REQ-008 tank_hit  in  1  tank destroyed.
REQ-009 tankx, tanky  out  10 each  tank top-left pixel, 32x32 sprite.
REQ-010 TankDir  out  4  facing, one-hot, same encoding as dir_req.
REQ-011 show_tank  out  1  tank alive/visible.
REQ-012 bullet_x, bullet_y  out  10 each  bullet top-left pixel, 8x8 sprite.
REQ-013 bullet_dir  out  4  bullet travel direction, one-hot.
REQ-014 bullet_active  out  1  bullet in flight.

Function
REQ-015 All outputs SHALL be registered; an update caused by an input at cycle N SHALL appear at cycle N+1.
REQ-016 Field bounds: tank x in [0,608], y in [0,448]; bullet x in [0,632], y in [0,472].
REQ-017 On frame_tick with dir_req nonzero and tank alive, direction SHALL be the highest-priority set bit (Up>Down>Left>Right); TankDir takes it and the tank moves TANK_SPEED in the same update.
REQ-018 Movement SHALL clamp at bounds; underflow SHALL be detected by compare before subtract (e.g. tanky=0, Up -> tanky stays 0, TankDir=Up).
REQ-019 dir_req=0 on frame_tick SHALL leave position and TankDir unchanged.
REQ-020 Fire edge = fire_btn high and registered previous fire_btn low; edge register resets to 1.
REQ-021 Bullet FSM states: IDLE, FLIGHT, COOLDOWN.
REQ-022 IDLE + fire edge + tank alive -> FLIGHT; bullet_dir=TankDir; spawn from current registered tank position: Up (tankx+12, tanky-8); Down (tankx+12, tanky+32); Left (tankx-8, tanky+12); Right (tankx+32, tanky+12).
REQ-023 If the spawn point lies outside bullet bounds, SHALL stay IDLE and not launch.
REQ-024 FLIGHT: on frame_tick bullet moves BULLET_SPEED in bullet_dir; if the next position leaves bullet bounds -> COOLDOWN without moving.
REQ-025 FLIGHT + bullet_hit (any cycle) -> COOLDOWN; bullet_hit SHALL win over a same-cycle frame_tick (no move).
REQ-026 Entering COOLDOWN SHALL deassert bullet_active, park bullet_x=bullet_y=PARK, load counter COOLDOWN_FRAMES.
REQ-027 COOLDOWN: counter decrements per frame_tick; reaching 0 -> IDLE.
REQ-028 Fire edges in FLIGHT or COOLDOWN SHALL be dropped, not queued.
REQ-029 In IDLE bullet_x=bullet_y=PARK, bullet_active=0.
REQ-030 Fire edge and frame_tick same cycle in IDLE: spawn uses pre-move tank position; tank still moves that cycle.
REQ-031 tank_hit SHALL clear show_tank; tank then ignores dir_req and fire; an in-flight bullet completes normally; state persists until Reset.

Reset
REQ-032 Reset SHALL force, next cycle: tankx=START_X, tanky=START_Y, TankDir=0001, show_tank=1, bullet_x=bullet_y=PARK, bullet_dir=0001, bullet_active=0, FSM=IDLE, counter=0, fire edge register=1.
REQ-033 Reset mid-flight or mid-cooldown SHALL abort immediately to REQ-032 values; fire_btn held through reset SHALL NOT fire.

Verification
REQ-034 Reset; dir_req=1000, 5 frame_ticks -> tankx=69, tanky=416, TankDir=1000.
REQ-035 Reset; dir_req=0001 for 420 ticks -> tanky=0 clamped; dir_req=0011 one tick -> Up wins, tanky=0.
REQ-036 Reset; fire edge -> next cycle bullet (76,408), bullet_dir=0001, active=1; 102 ticks -> y=0; next tick -> active=0, bullet=(1000,1000).
REQ-037 In FLIGHT, bullet_hit with frame_tick -> COOLDOWN, no move; fire edges during the following 8 ticks ignored; fire after 8th tick launches.
REQ-038 Tank at tanky=4 facing Up, fire edge -> no launch, FSM stays IDLE.
REQ-039 tank_hit in FLIGHT -> show_tank=0, bullet keeps moving to exit; Reset mid-flight -> all REQ-032 values next cycle.
